store_buffer_ctrl: RTL and testbench

//  Controller for the compare-capable store-buffer FIFO in the data cache path. Accepts CPU stores

---
 rtl/store_buffer_ctrl.sv | 145 ++++++++++++++
 tb/tb_store_buffer_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_ctrl.sv
// Store-buffer controller: accepts CPU stores into an external compare-capable FIFO,
// drains the head entry to memory over req/ack, answers load hazard lookups and sequences flushes.
module store_buffer_ctrl #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int C_DEPTH   = 4,
    parameter int C_TIMEOUT = 255
) (
    input  logic                     sClk_i,
    input  logic                     sRst_i,
    input  logic                     StoreValid_i,
    input  logic [W_ADDR-1:0]        StoreAddr_i,
    input  logic [W_DATA-1:0]        StoreData_i,
    output logic                     StoreReady_o,
    input  logic                     LoadValid_i,
    input  logic [W_ADDR-1:0]        LoadAddr_i,
    output logic                     Hazard_o,
    input  logic                     Flush_i,
    output logic                     FlushBusy_o,
    output logic                     FlushDone_o,
    output logic                     MemReq_o,
    output logic [W_ADDR-1:0]        MemAddr_o,
    output logic [W_DATA-1:0]        MemData_o,
    input  logic                     MemAck_i,
    output logic                     Error_o,
    output logic                     FifoWrite_o,
    output logic [W_ADDR+W_DATA-1:0] FifoWData_o,
    output logic                     FifoRead_o,
    output logic                     FifoCmpEn_o,
    output logic [W_ADDR-1:0]        FifoCmpData_o,
    input  logic                     FifoEmpty_i,
    input  logic                     FifoFull_i,
    input  logic [W_ADDR+W_DATA-1:0] FifoRData_i,
    input  logic [C_DEPTH-1:0]       FifoCmpRes_i
);

    localparam int W_CNT = $clog2(C_TIMEOUT + 1);
    localparam logic [W_CNT-1:0] TMO_MAX  = W_CNT'(C_TIMEOUT);
    localparam logic [W_CNT-1:0] TMO_LAST = W_CNT'(C_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [W_CNT-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              error_reg, error_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [W_ADDR-1:0] mem_addr_reg, mem_addr_next;
    logic [W_DATA-1:0] mem_data_reg, mem_data_next;

    logic mem_req;
    logic fifo_read;
    logic store_ready;
    logic fifo_write;
    logic slot_hit;
    logic hazard;

    always_ff @(posedge sClk_i) begin
        if (sRst_i) begin
            state_reg    <= S_IDLE;
            tmo_cnt_reg  <= '0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            error_reg    <= error_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        error_next    = error_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (!FifoEmpty_i) begin
                    state_next    = S_REQ;
                    tmo_cnt_next  = '0;
                    mem_addr_next = FifoRData_i[W_ADDR+W_DATA-1 -: W_ADDR];
                    mem_data_next = FifoRData_i[W_DATA-1:0];
                end
            end
            S_REQ: begin
                if (MemAck_i) begin
                    state_next = S_IDLE;
                end else if (tmo_cnt_reg != TMO_MAX) begin
                    // Counter saturates; the request is kept alive after the error fires.
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    if (tmo_cnt_reg == TMO_LAST) begin
                        error_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (busy_reg && FifoEmpty_i && state_reg == S_IDLE) begin
            busy_next = 1'b0;
            done_next = 1'b1;
        end else if (Flush_i) begin
            busy_next = 1'b1;
        end
    end

    always_comb begin
        mem_req     = (state_reg == S_REQ);
        // Gate the pop during reset so an ack racing the reset never consumes an entry.
        fifo_read   = mem_req && MemAck_i && !sRst_i;
        store_ready = !busy_reg && (!FifoFull_i || fifo_read);
        fifo_write  = StoreValid_i && store_ready;
        slot_hit    = |FifoCmpRes_i;
        hazard      = LoadValid_i && (slot_hit || (fifo_write && (StoreAddr_i == LoadAddr_i)));
    end

    assign StoreReady_o  = store_ready;
    assign FifoWrite_o   = fifo_write;
    assign FifoWData_o   = {StoreAddr_i, StoreData_i};
    assign FifoRead_o    = fifo_read;
    assign FifoCmpEn_o   = LoadValid_i;
    assign FifoCmpData_o = LoadAddr_i;
    assign Hazard_o      = hazard;
    assign MemReq_o      = mem_req;
    assign MemAddr_o     = mem_addr_reg;
    assign MemData_o     = mem_data_reg;
    assign Error_o       = error_reg;
    assign FlushBusy_o   = busy_reg;
    assign FlushDone_o   = done_reg;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: behavioural FIFO + transaction-level controller model,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_store_buffer_ctrl;

    localparam int WA  = 32;
    localparam int WD  = 32;
    localparam int D   = 4;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          sRst_i, StoreValid_i, LoadValid_i, Flush_i, MemAck_i;
    logic [WA-1:0] StoreAddr_i, LoadAddr_i;
    logic [WD-1:0] StoreData_i;
    logic          StoreReady_o, Hazard_o, FlushBusy_o, FlushDone_o, MemReq_o, Error_o;
    logic [WA-1:0] MemAddr_o, FifoCmpData_o;
    logic [WD-1:0] MemData_o;
    logic          FifoWrite_o, FifoRead_o, FifoCmpEn_o;
    logic [WA+WD-1:0] FifoWData_o, FifoRData_i;
    logic          FifoEmpty_i, FifoFull_i;
    logic [D-1:0]  FifoCmpRes_i;

    always #5 clk = ~clk;

    store_buffer_ctrl #(.W_ADDR(WA), .W_DATA(WD), .C_DEPTH(D), .C_TIMEOUT(TMO)) dut (
        .sClk_i(clk), .sRst_i(sRst_i),
        .StoreValid_i(StoreValid_i), .StoreAddr_i(StoreAddr_i), .StoreData_i(StoreData_i),
        .StoreReady_o(StoreReady_o),
        .LoadValid_i(LoadValid_i), .LoadAddr_i(LoadAddr_i), .Hazard_o(Hazard_o),
        .Flush_i(Flush_i), .FlushBusy_o(FlushBusy_o), .FlushDone_o(FlushDone_o),
        .MemReq_o(MemReq_o), .MemAddr_o(MemAddr_o), .MemData_o(MemData_o), .MemAck_i(MemAck_i),
        .Error_o(Error_o),
        .FifoWrite_o(FifoWrite_o), .FifoWData_o(FifoWData_o), .FifoRead_o(FifoRead_o),
        .FifoCmpEn_o(FifoCmpEn_o), .FifoCmpData_o(FifoCmpData_o),
        .FifoEmpty_i(FifoEmpty_i), .FifoFull_i(FifoFull_i), .FifoRData_i(FifoRData_i),
        .FifoCmpRes_i(FifoCmpRes_i)
    );

    // Buffered entries {addr,data}, oldest first; the FIFO shares the controller reset.
    logic [WA+WD-1:0] q[$];

    // Drain model: an outstanding write, its payload, and no-ack cycles spent waiting.
    logic          m_req = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [WA-1:0] m_addr = '0;
    logic [WD-1:0] m_data = '0;
    int            m_wait = 0;

    logic exp_ready, exp_write, exp_read, exp_hazard;
    int   n_checks = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    logic [WA-1:0] dut_pops[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        FifoEmpty_i  = (q.size() == 0);
        FifoFull_i   = (q.size() >= D);
        FifoRData_i  = (q.size() != 0) ? q[0] : '0;
        FifoCmpRes_i = '0;
        foreach (q[i]) begin
            if (LoadValid_i && q[i][WA+WD-1:WD] == LoadAddr_i) FifoCmpRes_i[i] = 1'b1;
        end
    endtask

    task automatic compute_exp();
        logic hit;
        hit = 1'b0;
        foreach (q[i]) if (q[i][WA+WD-1:WD] == LoadAddr_i) hit = 1'b1;
        exp_read   = m_req && MemAck_i && !sRst_i;
        exp_ready  = !m_busy && ((q.size() < D) || exp_read);
        exp_write  = StoreValid_i && exp_ready;
        exp_hazard = LoadValid_i && (hit || (exp_write && StoreAddr_i == LoadAddr_i));
    endtask

    // Advance the model over one clock edge using the inputs of the cycle just ended.
    task automatic model_update();
        logic was_empty;
        logic was_idle;
        if (sRst_i) begin
            m_req = 0; m_err = 0; m_busy = 0; m_done = 0; m_wait = 0;
            m_addr = '0; m_data = '0;
            q.delete();
        end else begin
            was_empty = (q.size() == 0);
            was_idle  = !m_req;
            m_done    = m_busy && was_empty && was_idle;
            if (m_done) m_busy = 1'b0;
            else if (Flush_i) m_busy = 1'b1;
            if (!m_req) begin
                if (!was_empty) begin
                    m_req  = 1'b1;
                    m_addr = q[0][WA+WD-1:WD];
                    m_data = q[0][WD-1:0];
                    m_wait = 0;
                end
            end else if (MemAck_i) begin
                m_req = 1'b0;
            end else if (m_wait < TMO) begin
                m_wait++;
                if (m_wait == TMO) m_err = 1'b1;
            end
            if (exp_read)  void'(q.pop_front());
            if (exp_write) q.push_back({StoreAddr_i, StoreData_i});
        end
    endtask

    // mode: 0 never ack, 1 random ack, 2 ack on third request cycle, 3 ack immediately
    task automatic step(input logic sv, input logic [WA-1:0] sa, input logic [WD-1:0] sd,
                        input logic lv, input logic [WA-1:0] la, input logic fl,
                        input int mode, input logic rst);
        logic a;
        @(posedge clk);
        model_update();
        #1;
        case (mode)
            0:       a = 1'b0;
            1:       a = m_req && ($urandom_range(0, 9) < 3);
            2:       a = m_req && (m_wait == 2);
            default: a = m_req;
        endcase
        sRst_i = rst; StoreValid_i = sv; StoreAddr_i = sa; StoreData_i = sd;
        LoadValid_i = lv; LoadAddr_i = la; Flush_i = fl; MemAck_i = a;
        drive_fifo();
        compute_exp();
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, mode, 0);
    endtask

    task automatic push(input logic [WA-1:0] sa, input logic [WD-1:0] sd, input int mode);
        step(1, sa, sd, 0, '0, 0, mode, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("store_ready", StoreReady_o, exp_ready);
            chk("fifo_write",  FifoWrite_o,  exp_write);
            chk("fifo_wdata",  FifoWData_o,  {StoreAddr_i, StoreData_i});
            chk("fifo_read",   FifoRead_o,   exp_read);
            chk("cmp_en",      FifoCmpEn_o,  LoadValid_i);
            chk("cmp_data",    FifoCmpData_o, LoadAddr_i);
            chk("hazard",      Hazard_o,     exp_hazard);
            chk("mem_req",     MemReq_o,     m_req);
            chk("mem_addr",    MemAddr_o,    m_addr);
            chk("mem_data",    MemData_o,    m_data);
            chk("error",       Error_o,      m_err);
            chk("flush_busy",  FlushBusy_o,  m_busy);
            chk("flush_done",  FlushDone_o,  m_done);
            if (FifoRead_o) dut_pops.push_back(MemAddr_o);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int reqcnt, last_pop, done_at, bad;
        logic [WA-1:0] ra;
        sRst_i = 1; StoreValid_i = 0; StoreAddr_i = '0; StoreData_i = '0;
        LoadValid_i = 0; LoadAddr_i = '0; Flush_i = 0; MemAck_i = 0;
        drive_fifo();
        compute_exp();

        step(0, '0, '0, 0, '0, 0, 0, 1);
        step(0, '0, '0, 0, '0, 0, 0, 1);
        chk_en = 1'b1;
        #1;
        chk("rst_mem_req", MemReq_o, 0);
        chk("rst_mem_addr", MemAddr_o, 0);
        chk("rst_error", Error_o, 0);
        chk("rst_busy", FlushBusy_o, 0);
        chk("rst_done", FlushDone_o, 0);

        // Two stores drained in order, each acked on its third request cycle.
        dut_pops.delete();
        push(32'h100, 32'hA, 2);
        push(32'h104, 32'hB, 2);
        idle(20, 2);
        chk("order_count", dut_pops.size(), 2);
        if (dut_pops.size() == 2) begin
            chk("order_first", dut_pops[0], 32'h100);
            chk("order_second", dut_pops[1], 32'h104);
        end
        #1;
        chk("order_idle_req", MemReq_o, 0);

        // Full FIFO refuses stores until the cycle the head is popped.
        for (int i = 0; i < D; i++) push(32'h300 + 4 * i, 32'h30 + i, 0);
        push(32'h310, 32'h34, 0);
        #1;
        chk("full_ready", StoreReady_o, 0);
        push(32'h310, 32'h34, 3);
        #1;
        chk("full_pop", FifoRead_o, 1);
        chk("full_push_ready", StoreReady_o, 1);
        chk("full_push", FifoWrite_o, 1);
        idle(40, 3);

        // Hazard lookups against a held entry and a same-cycle store.
        push(32'h200, 32'h55, 0);
        step(0, '0, '0, 1, 32'h200, 0, 0, 0);
        #1;
        chk("haz_buffered", Hazard_o, 1);
        step(0, '0, '0, 1, 32'h204, 0, 0, 0);
        #1;
        chk("haz_miss", Hazard_o, 0);
        step(1, 32'h204, 32'h66, 1, 32'h204, 0, 0, 0);
        #1;
        chk("haz_same_cycle", Hazard_o, 1);
        step(0, '0, '0, 0, 32'h200, 0, 0, 0);
        #1;
        chk("haz_no_load", Hazard_o, 0);
        idle(40, 3);

        // Flush on an empty idle buffer: busy one cycle, then done pulse.
        step(0, '0, '0, 0, '0, 1, 3, 0);
        idle(1, 3);
        #1;
        chk("eflush_busy", FlushBusy_o, 1);
        chk("eflush_nodone", FlushDone_o, 0);
        idle(1, 3);
        #1;
        chk("eflush_clear", FlushBusy_o, 0);
        chk("eflush_done", FlushDone_o, 1);
        idle(1, 3);
        #1;
        chk("eflush_pulse", FlushDone_o, 0);

        // Flush with buffered entries while stores keep coming.
        for (int i = 0; i < 3; i++) push(32'h400 + 4 * i, 32'h40 + i, 0);
        step(1, 32'h40C, 32'h43, 0, '0, 1, 2, 0);
        last_pop = -1; done_at = -1; bad = 0;
        for (int i = 0; i < 100; i++) begin
            push(32'h500 + 4 * i, i, 2);
            #1;
            if (FifoRead_o) last_pop = i;
            if (FlushBusy_o && FifoWrite_o) bad++;
            if (FlushDone_o) begin
                done_at = i;
                break;
            end
        end
        chk("flush_push_while_busy", bad, 0);
        chk("flush_done_seen", done_at >= 0, 1);
        if (done_at >= 0) chk("flush_done_gap", done_at - last_pop, 2);
        idle(40, 3);

        // Timeout: no ack for 255 request cycles raises the sticky error.
        push(32'h600, 32'h77, 0);
        reqcnt = 0;
        for (int i = 0; i < 300; i++) begin
            idle(1, 0);
            #1;
            if (MemReq_o) reqcnt++;
            if (reqcnt == TMO) chk("tmo_not_yet", Error_o, 0);
            if (reqcnt == TMO + 1) break;
        end
        chk("tmo_reached", reqcnt, TMO + 1);
        chk("tmo_error", Error_o, 1);
        chk("tmo_req_kept", MemReq_o, 1);
        idle(1, 3);
        #1;
        chk("tmo_ack_pop", FifoRead_o, 1);
        chk("tmo_ack_addr", MemAddr_o, 32'h600);
        idle(1, 3);
        #1;
        chk("tmo_req_drop", MemReq_o, 0);
        chk("tmo_sticky", Error_o, 1);

        // Reset during a request: no pop, request and error cleared.
        push(32'h700, 32'h88, 0);
        idle(3, 0);
        #1;
        chk("rreq_active", MemReq_o, 1);
        step(0, '0, '0, 0, '0, 0, 3, 1);
        #1;
        chk("rreq_no_pop", FifoRead_o, 0);
        step(0, '0, '0, 0, '0, 0, 3, 0);
        #1;
        chk("rreq_req_low", MemReq_o, 0);
        chk("rreq_error", Error_o, 0);
        chk("rreq_no_pop_after", FifoRead_o, 0);

        // Randomized traffic over a small address window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            ra = 32'h800 + 4 * $urandom_range(0, 7);
            step($urandom_range(0, 1), ra, $urandom, $urandom_range(0, 1),
                 32'h800 + 4 * $urandom_range(0, 7), ($urandom_range(0, 29) == 0), 1,
                 ($urandom_range(0, 199) == 0));
        end
        idle(40, 3);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
